// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
//   Memory bus controller between the CPU control FSM and the memory system.
//   A request (mem_cmd/mem_addr/mem_wdata) is sampled once, in IDLE, and is
//   steered to a synchronous single-port RAM or to memory-mapped I/O
//   (LED output register, switch inputs). Completion is signalled by a
//   one-cycle mem_ready strobe; mem_err accompanies it for unmapped or
//   illegal accesses.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   reset      in   synchronous active-high reset
//   mem_cmd    in   2'b00 none, 2'b10 read, 2'b01 write, 2'b11 illegal
//   mem_addr   in   request address
//   mem_wdata  in   request write data
//   mem_rdata  out  registered read data, held until the next completed read
//   mem_ready  out  one-cycle completion strobe
//   mem_err    out  one-cycle error strobe, coincident with mem_ready
//   ram_addr   out  registered RAM word address
//   ram_din    out  registered RAM write data
//   ram_we     out  registered RAM write enable
//   ram_dout   in   RAM read data, valid RAM_LAT edges after ram_addr settles
//   sw_in      in   switch inputs
//   led_out    out  LED register

module mem_bus_ctrl #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter int                RAM_LAT  = 1,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_err,
  output logic [ADDR_W-2:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic [7:0]        sw_in,
  output logic [7:0]        led_out
);

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b10;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_ILL  = 2'b11;

  // RAM_LAT is limited to 1..7, so three bits always hold the wait count.
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              err_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [ADDR_W-2:0] ram_addr_reg;
  logic [DATA_W-1:0] ram_din_reg;
  logic              ram_we_reg;
  logic [7:0]        led_reg;

  // Address decode: the lower half of the address space is RAM, two single
  // words in the upper half are I/O, everything else is unmapped.
  logic is_ram;
  logic is_led;
  logic is_sw;

  assign is_ram = ~mem_addr[ADDR_W-1];
  assign is_led = (mem_addr == LED_ADDR);
  assign is_sw  = (mem_addr == SW_ADDR);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (mem_cmd != CMD_NONE) begin
          if (mem_cmd == CMD_RD && is_ram) begin
            state_next = RD_WAIT;
          end else if (mem_cmd == CMD_WR && is_ram) begin
            state_next = WR;
          end else begin
            // I/O, unmapped and illegal accesses all finish immediately.
            state_next = DONE;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
        end
      end
      WR:      state_next = DONE;
      // DONE never accepts a request, which keeps mem_ready from being
      // high on two consecutive cycles.
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM outputs
  // ---------------------------------------------------------------------
  always_comb begin
    mem_ready = 1'b0;
    mem_err   = 1'b0;
    if (state_reg == DONE) begin
      mem_ready = 1'b1;
      mem_err   = err_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers: request capture, wait counter, read data, I/O
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
      ram_addr_reg <= '0;
      ram_din_reg  <= '0;
      ram_we_reg   <= 1'b0;
      led_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          case (mem_cmd)
            CMD_RD: begin
              if (is_ram) begin
                ram_addr_reg <= mem_addr[ADDR_W-2:0];
                cnt_reg      <= CNT_W'(RAM_LAT);
              end else if (is_led || is_sw) begin
                // Every I/O read returns the switches, zero-extended.
                rdata_reg <= DATA_W'(sw_in);
              end else begin
                rdata_reg <= '0;
                err_reg   <= 1'b1;
              end
            end
            CMD_WR: begin
              if (is_ram) begin
                ram_addr_reg <= mem_addr[ADDR_W-2:0];
                ram_din_reg  <= mem_wdata;
                ram_we_reg   <= 1'b1;
              end else if (is_led) begin
                led_reg <= mem_wdata[7:0];
              end else if (!is_sw) begin
                // Writes to the switch address are silently dropped;
                // anything else outside RAM/I/O is an error.
                err_reg <= 1'b1;
              end
            end
            CMD_ILL: begin
              err_reg <= 1'b1;
            end
            default: begin
            end
          endcase
        end
        RD_WAIT: begin
          // ram_addr_reg is untouched here, so the RAM sees a stable
          // address for the whole wait.
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            rdata_reg <= ram_dout;
          end
        end
        WR: begin
          ram_we_reg <= 1'b0;
        end
        DONE: begin
          err_reg <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_rdata = rdata_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_din   = ram_din_reg;
  assign ram_we    = ram_we_reg;
  assign led_out   = led_reg;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Testbench for mem_bus_ctrl. Two instances run side by side on the same
// request stream: index 0 with RAM_LAT=1, index 1 with RAM_LAT=3, each with
// its own behavioural RAM of matching latency.

module tb_mem_bus_ctrl;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b10;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_ILL  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [7:0]  sw_in;

  logic [15:0] rdata    [2];
  logic        ready    [2];
  logic        err      [2];
  logic [7:0]  ram_addr [2];
  logic [15:0] ram_din  [2];
  logic        ram_we   [2];
  logic [15:0] ram_dout [2];
  logic [7:0]  led      [2];

  int errors = 0;
  int checks = 0;

  // Per-transaction observations filled in by issue().
  int lat     [2];
  int we_cnt  [2];
  int rdy_cnt [2];
  int err_cnt [2];
  int stray   [2];
  int consec  [2];
  bit moved   [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;

    logic [15:0] mem  [256];
    logic [15:0] pipe [LAT];

    initial begin
      for (int j = 0; j < 256; j++) mem[j] = 16'h0000;
    end

    // Synchronous RAM: data for an address appears LAT edges after it.
    always @(posedge clk) begin
      if (ram_we[gi]) mem[ram_addr[gi]] <= ram_din[gi];
      pipe[0] <= mem[ram_addr[gi]];
      for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
    end
    assign ram_dout[gi] = pipe[LAT-1];

    mem_bus_ctrl #(.RAM_LAT(LAT)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .mem_cmd   (mem_cmd),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (rdata[gi]),
      .mem_ready (ready[gi]),
      .mem_err   (err[gi]),
      .ram_addr  (ram_addr[gi]),
      .ram_din   (ram_din[gi]),
      .ram_we    (ram_we[gi]),
      .ram_dout  (ram_dout[gi]),
      .sw_in     (sw_in),
      .led_out   (led[gi])
    );
  end

  // Present one request for exactly one edge (E0), then scramble the request
  // inputs and watch both instances for 12 cycles. lat = k means mem_ready
  // was seen high in the cycle after edge Ek.
  task automatic issue(input logic [1:0] cmd, input logic [8:0] addr,
                       input logic [15:0] wd);
    logic [7:0] a0 [2];
    bit         prev [2];
    @(negedge clk);
    mem_cmd   = cmd;
    mem_addr  = addr;
    mem_wdata = wd;
    @(negedge clk);
    mem_cmd   = CMD_NONE;
    mem_addr  = ~addr;
    mem_wdata = ~wd;
    for (int i = 0; i < 2; i++) begin
      lat[i] = -1; we_cnt[i] = 0; rdy_cnt[i] = 0; err_cnt[i] = 0;
      stray[i] = 0; consec[i] = 0; moved[i] = 1'b0;
      a0[i] = ram_addr[i]; prev[i] = 1'b0;
    end
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (lat[i] < 0 && ram_addr[i] !== a0[i]) moved[i] = 1'b1;
        if (ready[i] === 1'b1) begin
          if (lat[i] < 0) lat[i] = k;
          rdy_cnt[i]++;
          if (prev[i]) consec[i]++;
        end
        if (err[i] === 1'b1) begin
          err_cnt[i]++;
          if (ready[i] !== 1'b1) stray[i]++;
        end
        if (ram_we[i] === 1'b1) we_cnt[i]++;
        prev[i] = (ready[i] === 1'b1);
      end
      @(negedge clk);
    end
    $display("txn cmd=%b addr=%h wdata=%h : lat=%0d/%0d rdata=%h/%h err=%0d/%0d led=%h/%h",
             cmd, addr, wd, lat[0], lat[1], rdata[0], rdata[1],
             err_cnt[0], err_cnt[1], led[0], led[1]);
  endtask

  task automatic test_reset();
    int rdy [2];
    reset = 1'b1; mem_cmd = CMD_NONE; mem_addr = '0; mem_wdata = '0; sw_in = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({rdata[i], ready[i], err[i], ram_addr[i], ram_din[i], ram_we[i], led[i]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: rdata=%h ready=%b err=%b ram_addr=%h ram_din=%h ram_we=%b led=%h, required all zero",
                 i, rdata[i], ready[i], err[i], ram_addr[i], ram_din[i], ram_we[i], led[i]);
      end
    end
    reset = 1'b0;
    rdy[0] = 0; rdy[1] = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (ready[i] !== 1'b0) rdy[i]++;
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdy[i] != 0) begin
        errors++;
        $display("FAIL idle_ready dut%0d: ready cycles=%0d required 0", i, rdy[i]);
      end
    end
    $display("txn reset + 10 idle cycles done");
  endtask

  task automatic test_ram();
    int exp_rd;
    issue(CMD_WR, 9'h005, 16'h1234);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (lat[i] != 1 || rdy_cnt[i] != 1 || err_cnt[i] != 0) begin
        errors++;
        $display("FAIL ram_wr_timing dut%0d: lat=%0d readies=%0d errs=%0d required 1/1/0",
                 i, lat[i], rdy_cnt[i], err_cnt[i]);
      end
      checks++;
      if (we_cnt[i] != 1 || ram_addr[i] !== 8'h05 || ram_din[i] !== 16'h1234) begin
        errors++;
        $display("FAIL ram_wr_port dut%0d: we_cycles=%0d addr=%h din=%h required 1/05/1234",
                 i, we_cnt[i], ram_addr[i], ram_din[i]);
      end
      checks++;
      if (rdata[i] !== 16'h0000) begin
        errors++;
        $display("FAIL ram_wr_rdata dut%0d: rdata=%h required 0000", i, rdata[i]);
      end
    end
    issue(CMD_WR, 9'h006, 16'h7777);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (lat[i] != 1 || we_cnt[i] != 1) begin
        errors++;
        $display("FAIL ram_wr2 dut%0d: lat=%0d we_cycles=%0d required 1/1", i, lat[i], we_cnt[i]);
      end
    end
    // RAM output currently shows word 6, so an early capture returns 7777.
    issue(CMD_RD, 9'h005, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      exp_rd = (i == 0) ? 2 : 4;
      checks++;
      if (lat[i] != exp_rd || rdy_cnt[i] != 1 || err_cnt[i] != 0 || we_cnt[i] != 0) begin
        errors++;
        $display("FAIL ram_rd_timing dut%0d: lat=%0d readies=%0d errs=%0d we=%0d required %0d/1/0/0",
                 i, lat[i], rdy_cnt[i], err_cnt[i], we_cnt[i], exp_rd);
      end
      checks++;
      if (rdata[i] !== 16'h1234) begin
        errors++;
        $display("FAIL ram_rd_data dut%0d: rdata=%h required 1234", i, rdata[i]);
      end
      checks++;
      if (moved[i] || ram_addr[i] !== 8'h05) begin
        errors++;
        $display("FAIL ram_rd_addr_hold dut%0d: moved=%0d ram_addr=%h required 0/05", i, moved[i], ram_addr[i]);
      end
    end
    issue(CMD_RD, 9'h006, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdata[i] !== 16'h7777) begin
        errors++;
        $display("FAIL ram_rd2_data dut%0d: rdata=%h required 7777", i, rdata[i]);
      end
    end
  endtask

  task automatic test_io();
    issue(CMD_WR, 9'h100, 16'hABCD);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (led[i] !== 8'hCD || lat[i] != 0 || err_cnt[i] != 0 || we_cnt[i] != 0) begin
        errors++;
        $display("FAIL led_write dut%0d: led=%h lat=%0d errs=%0d we=%0d required CD/0/0/0",
                 i, led[i], lat[i], err_cnt[i], we_cnt[i]);
      end
      checks++;
      if (rdata[i] !== 16'h7777) begin
        errors++;
        $display("FAIL led_write_rdata dut%0d: rdata=%h required 7777", i, rdata[i]);
      end
    end
    sw_in = 8'h5A;
    issue(CMD_RD, 9'h140, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdata[i] !== 16'h005A || lat[i] != 0 || err_cnt[i] != 0) begin
        errors++;
        $display("FAIL sw_read dut%0d: rdata=%h lat=%0d errs=%0d required 005A/0/0",
                 i, rdata[i], lat[i], err_cnt[i]);
      end
    end
    issue(CMD_WR, 9'h140, 16'h0011);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (lat[i] != 0 || err_cnt[i] != 0 || led[i] !== 8'hCD || rdata[i] !== 16'h005A) begin
        errors++;
        $display("FAIL sw_write dut%0d: lat=%0d errs=%0d led=%h rdata=%h required 0/0/CD/005A",
                 i, lat[i], err_cnt[i], led[i], rdata[i]);
      end
    end
  endtask

  task automatic test_errors();
    issue(CMD_WR, 9'h180, 16'h00FF);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (lat[i] != 0 || err_cnt[i] != 1 || stray[i] != 0 || rdata[i] !== 16'h005A || led[i] !== 8'hCD) begin
        errors++;
        $display("FAIL unmapped_write dut%0d: lat=%0d errs=%0d stray=%0d rdata=%h led=%h required 0/1/0/005A/CD",
                 i, lat[i], err_cnt[i], stray[i], rdata[i], led[i]);
      end
    end
    issue(CMD_RD, 9'h1FF, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdata[i] !== 16'h0000 || lat[i] != 0) begin
        errors++;
        $display("FAIL unmapped_read dut%0d: rdata=%h lat=%0d required 0000/0", i, rdata[i], lat[i]);
      end
      checks++;
      if (rdy_cnt[i] != 1 || err_cnt[i] != 1 || stray[i] != 0 || consec[i] != 0) begin
        errors++;
        $display("FAIL unmapped_read_strobe dut%0d: readies=%0d errs=%0d stray=%0d consec=%0d required 1/1/0/0",
                 i, rdy_cnt[i], err_cnt[i], stray[i], consec[i]);
      end
    end
    issue(CMD_ILL, 9'h100, 16'h00EE);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (lat[i] != 0 || err_cnt[i] != 1 || stray[i] != 0 || we_cnt[i] != 0 || led[i] !== 8'hCD) begin
        errors++;
        $display("FAIL illegal_cmd dut%0d: lat=%0d errs=%0d stray=%0d we=%0d led=%h required 0/1/0/0/CD",
                 i, lat[i], err_cnt[i], stray[i], we_cnt[i], led[i]);
      end
    end
    issue(CMD_RD, 9'h140, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (err_cnt[i] != 0 || rdata[i] !== 16'h005A) begin
        errors++;
        $display("FAIL err_cleared dut%0d: errs=%0d rdata=%h required 0/005A", i, err_cnt[i], rdata[i]);
      end
    end
  endtask

  // A read of the switch address is held for six edges while the switches
  // change every cycle: accepts land on E0, E2, E4 (DONE blocks E1, E3, E5).
  task automatic test_back_to_back();
    logic        exp_rdy;
    logic [15:0] exp_data;
    @(negedge clk);
    mem_cmd = CMD_RD; mem_addr = 9'h140; sw_in = 8'h10;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_rdy  = (k == 1 || k == 3 || k == 5);
      exp_data = 16'h0010 + 16'(k - 1);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ready[i] !== exp_rdy) begin
          errors++;
          $display("FAIL b2b_ready dut%0d cycle %0d: ready=%b required %b", i, k, ready[i], exp_rdy);
        end
        if (exp_rdy) begin
          checks++;
          if (rdata[i] !== exp_data) begin
            errors++;
            $display("FAIL b2b_data dut%0d cycle %0d: rdata=%h required %h", i, k, rdata[i], exp_data);
          end
        end
      end
      if (k < 6) sw_in = 8'h10 + 8'(k);
      else mem_cmd = CMD_NONE;
    end
    $display("txn back-to-back switch reads: rdata=%h/%h", rdata[0], rdata[1]);
  endtask

  task automatic test_reset_mid_read();
    int rdy [2];
    int exp_rd;
    @(negedge clk);
    mem_cmd = CMD_RD; mem_addr = 9'h005;
    @(negedge clk);                 // E0 accepted
    mem_cmd = CMD_NONE;
    @(negedge clk);                 // E1: both instances still in RD_WAIT
    reset = 1'b1;
    @(negedge clk);                 // E2 is the reset edge
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdata[i] !== 16'h0000 || ready[i] !== 1'b0 || ram_addr[i] !== 8'h00) begin
        errors++;
        $display("FAIL rst_rdwait dut%0d: rdata=%h ready=%b ram_addr=%h required 0000/0/00",
                 i, rdata[i], ready[i], ram_addr[i]);
      end
    end
    rdy[0] = 0; rdy[1] = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (ready[i] !== 1'b0) rdy[i]++;
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdy[i] != 0) begin
        errors++;
        $display("FAIL rst_rdwait_noready dut%0d: ready cycles=%0d required 0", i, rdy[i]);
      end
    end
    $display("txn read aborted by reset in RD_WAIT");
    issue(CMD_RD, 9'h005, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      exp_rd = (i == 0) ? 2 : 4;
      checks++;
      if (lat[i] != exp_rd || rdata[i] !== 16'h1234) begin
        errors++;
        $display("FAIL rst_fresh_read dut%0d: lat=%0d rdata=%h required %0d/1234", i, lat[i], rdata[i], exp_rd);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int rdy [2];
    @(negedge clk);
    mem_cmd = CMD_WR; mem_addr = 9'h007; mem_wdata = 16'h4242;
    @(negedge clk);                 // E0 accepted, now in WR
    mem_cmd = CMD_NONE;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ram_we[i] !== 1'b1) begin
        errors++;
        $display("FAIL wr_we_high dut%0d: ram_we=%b required 1", i, ram_we[i]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rdy[0] = 0; rdy[1] = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ram_we[i] !== 1'b0) begin
        errors++;
        $display("FAIL rst_wr_we dut%0d: ram_we=%b required 0", i, ram_we[i]);
      end
    end
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 2; i++) if (ready[i] !== 1'b0) rdy[i]++;
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdy[i] != 0) begin
        errors++;
        $display("FAIL rst_wr_noready dut%0d: ready cycles=%0d required 0", i, rdy[i]);
      end
    end
    $display("txn write aborted by reset in WR");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ram();
    test_io();
    test_errors();
    test_back_to_back();
    test_reset_mid_read();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
